spi_mult_master: RTL

//  SPI master that drives the SmolBoi multiplier peripheral. It accepts an operand pair

---
 rtl/smol_spi_pkg.sv | 31 +++
 rtl/spi_mult_master_if.sv | 32 +++
 rtl/spi_sclk_gen.sv | 55 +++++
 rtl/spi_mult_master.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/smol_spi_pkg.sv
// ---------------------------------------------------------------------------
// smol_spi_pkg
//   Definitions shared by the SmolBoi SPI master and the peripheral's bench:
//   - default operand width, SCLK divider and compute-gap length
//   - FSM state encoding of the master
//   - helper that decodes which states keep chip select asserted
// ---------------------------------------------------------------------------
package smol_spi_pkg;

  // Operand width; the product is twice this.
  localparam int W_DEF          = 4;
  // CLK cycles per SCLK half-period (must be >= 2).
  localparam int SCLK_DIV_DEF   = 10;
  // Full SCLK periods between the last operand bit and the first product bit.
  localparam int WAIT_SCLKS_DEF = 250;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // CS is asserted for the whole serial exchange, SETUP through RECV.
  function automatic logic cs_active(input state_e s);
    return (s == SETUP) || (s == SEND) || (s == WAIT) || (s == RECV);
  endfunction

endpackage

// File: rtl/spi_mult_master_if.sv
// ---------------------------------------------------------------------------
// spi_mult_master_if
//   Host-side handshake of the SmolBoi SPI master.
//   start_valid/start_ready : operand pair transfer (both high on a CLK edge)
//   op_a, op_b              : operands, sampled at the handshake
//   result, result_valid    : 2W-bit product and its one-cycle update strobe
//   busy                    : master is somewhere other than IDLE
//   Modports: master = the requesting host, slave = spi_mult_master.
// ---------------------------------------------------------------------------
interface spi_mult_master_if #(
  parameter int W = smol_spi_pkg::W_DEF
);

  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic           busy;

  modport master (
    output start_valid, op_a, op_b,
    input  start_ready, result, result_valid, busy
  );

  modport slave (
    input  start_valid, op_a, op_b,
    output start_ready, result, result_valid, busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
//   Divides CLK down to SCLK. A counter runs 0..SCLK_DIV-1 while en is high;
//   at terminal count SCLK toggles. The cycle whose edge raises SCLK carries
//   rise_tick, the cycle whose edge lowers it carries fall_tick, so the FSM
//   acts on the same edge at which the pin changes.
//   Ports:
//     CLK, RESET : system clock, synchronous active-high reset
//     en         : run the divider
//     clr        : zero the counter and force SCLK low (wins over en)
//     SCLK       : SPI clock, idles low
//     rise_tick  : SCLK goes 0->1 on this edge
//     fall_tick  : SCLK goes 1->0 on this edge
// ---------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int SCLK_DIV = smol_spi_pkg::SCLK_DIV_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic SCLK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(SCLK_DIV);

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = en && !clr && (cnt == CW'(SCLK_DIV - 1));
  assign rise_tick = term && !SCLK;
  assign fall_tick = term &&  SCLK;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt  <= '0;
      SCLK <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      SCLK <= 1'b0;
    end else if (en) begin
      if (term) begin
        cnt  <= '0;
        SCLK <= ~SCLK;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_mult_master.sv
// ---------------------------------------------------------------------------
// spi_mult_master
//   SPI master for the SmolBoi multiplier peripheral. An operand pair taken
//   over the host handshake is shifted out on MOSI (A then B, MSB first),
//   followed by a fixed compute gap, after which the 2W-bit product is
//   shifted in from MISO and presented on result with a one-cycle strobe.
//   Sequence: IDLE -> SETUP -> SEND -> WAIT -> RECV -> DONE -> IDLE.
//   Ports:
//     CLK, RESET : system clock, synchronous active-high reset
//     host       : handshake interface (slave modport)
//     SCLK       : SPI clock, idles low; slave samples MOSI on its rise
//     CS         : active-high chip select, high from SETUP through RECV
//     MOSI       : serial operands
//     MISO       : serial product from the peripheral
// ---------------------------------------------------------------------------
module spi_mult_master
  import smol_spi_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int SCLK_DIV   = SCLK_DIV_DEF,
  parameter int WAIT_SCLKS = WAIT_SCLKS_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  spi_mult_master_if.slave    host,
  output logic                SCLK,
  output logic                CS,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int PW = 2 * W;
  localparam int BW = $clog2(PW + 1);
  localparam int WW = $clog2(WAIT_SCLKS + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [PW-1:0]   tx;
  logic [PW-1:0]   rx;
  logic [PW-1:0]   result_q;
  logic            result_valid_q;
  logic            cs_q;
  logic            mosi_q;

  logic            hs;
  logic            div_en;
  logic            div_clr;
  logic            rise_tick;
  logic            fall_tick;
  logic            load_mosi;
  logic            send_last;
  logic            wait_last;
  logic            recv_last;

  spi_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .CLK       (CLK),
    .RESET     (RESET),
    .en        (div_en),
    .clr       (div_clr),
    .SCLK      (SCLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM next state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hs        = 1'b0;
    div_en    = cs_active(state_q);
    div_clr   = 1'b0;
    load_mosi = 1'b0;
    send_last = 1'b0;
    wait_last = 1'b0;
    recv_last = 1'b0;

    case (state_q)
      IDLE: begin
        hs      = host.start_valid;
        div_clr = host.start_valid;
        if (host.start_valid) state_d = SETUP;
      end
      SETUP: begin
        // Closing fall of the dummy period presents the first operand bit.
        load_mosi = fall_tick;
        if (fall_tick) state_d = SEND;
      end
      SEND: begin
        // After the 2W-th rise the next fall ends the operand phase.
        send_last = fall_tick && (bit_cnt == BW'(PW));
        load_mosi = fall_tick && (bit_cnt != BW'(PW));
        if (send_last) state_d = WAIT;
      end
      WAIT: begin
        wait_last = rise_tick && (wait_cnt == WW'(WAIT_SCLKS - 1));
        if (wait_last) state_d = RECV;
      end
      RECV: begin
        recv_last = rise_tick && (bit_cnt == BW'(PW - 1));
        if (recv_last) state_d = DONE;
      end
      DONE: begin
        div_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters, SPI pin registers and result
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      cs_q           <= 1'b0;
      mosi_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      cs_q           <= cs_active(state_d);

      if (load_mosi)      mosi_q <= tx[PW-1];
      else if (send_last) mosi_q <= 1'b0;

      case (state_q)
        SEND: begin
          if (rise_tick)      bit_cnt <= bit_cnt + BW'(1);
          else if (send_last) bit_cnt <= '0;
        end
        WAIT: begin
          if (wait_last)      wait_cnt <= '0;
          else if (rise_tick) wait_cnt <= wait_cnt + WW'(1);
        end
        RECV: begin
          if (recv_last)      bit_cnt <= '0;
          else if (rise_tick) bit_cnt <= bit_cnt + BW'(1);
        end
        DONE: begin
          result_q       <= rx;
          result_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shift registers
  // -------------------------------------------------------------------------
  // NOTE: tx and rx carry no reset: tx is loaded at every handshake and rx is
  // fully refilled by 2W samples before it is ever copied into result.
  // MISO comes from a peripheral on this same CLK, so it is sampled directly.
  always_ff @(posedge CLK) begin
    if (hs)             tx <= {host.op_a, host.op_b};
    else if (load_mosi) tx <= {tx[PW-2:0], 1'b0};

    if (state_q == RECV && rise_tick) rx <= {rx[PW-2:0], MISO};
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign CS                = cs_q;
  assign MOSI              = mosi_q;
  assign host.result       = result_q;
  assign host.result_valid = result_valid_q;
  assign host.busy         = (state_q != IDLE);
  assign host.start_ready  = (state_q == IDLE);

endmodule
